// File: rtl/led_pio_ctrl.sv
// led_pio_ctrl
//   Avalon-MM output PIO for board LEDs / general-purpose outputs.
//   Zero-wait-state slave providing:
//     - a DATA register with atomic set and clear writes
//     - a per-bit blink mask gated by a programmable prescaler
//     - a registered, glitch-free output stage.
//
//   Optional feature, macro LED_PIO_CTRL_PWM_EN:
//     adds an 8-bit DUTY register and a free-running PWM gate on all outputs.
//
//   Ports:
//     clk        system clock
//     reset_n    asynchronous active-low reset
//     address    word address (0 DATA, 1 BLINK_MASK, 2 PERIOD, 3 STATUS,
//                4 OUTSET, 5 OUTCLEAR, 6 DUTY, 7 reserved)
//     chipselect slave select
//     write_n    active-low write strobe
//     writedata  write data; only the low bits of each register are used
//     readdata   combinational read data, zero-extended
//     out_port   registered LED/GPIO drive
module led_pio_ctrl #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter int                PRESC_W     = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
  localparam logic [2:0] ADDR_DUTY     = 3'd6;

  logic               wr;
  logic [WIDTH-1:0]   wd;
  logic [PRESC_W-1:0] wp;
  logic [WIDTH-1:0]   data_reg;
  logic [WIDTH-1:0]   blink_mask;
  logic [PRESC_W-1:0] period;
  logic [PRESC_W-1:0] cnt;
  logic               phase;
  logic               pwm_on;
  logic [WIDTH-1:0]   out_next;

  // Upper writedata bits beyond the register widths are intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];
  assign wp = writedata[PRESC_W-1:0];

  // DATA and BLINK_MASK; OUTSET/OUTCLEAR modify DATA atomically.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg   <= RESET_VALUE;
      blink_mask <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:     data_reg   <= wd;
        ADDR_OUTSET:   data_reg   <= data_reg | wd;
        ADDR_OUTCLEAR: data_reg   <= data_reg & ~wd;
        ADDR_MASK:     blink_mask <= wd;
        default:       ;
      endcase
    end
  end

  // Blink prescaler. A PERIOD write restarts the blink in the on phase and
  // takes priority over a coincident terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period <= '0;
      cnt    <= '0;
      phase  <= 1'b1;
    end else if (wr && address == ADDR_PERIOD) begin
      period <= wp;
      cnt    <= '0;
      phase  <= 1'b1;
    end else if (period == '0) begin
      cnt    <= '0;
      phase  <= 1'b1;
    end else if (cnt == period) begin
      cnt    <= '0;
      phase  <= ~phase;
    end else begin
      cnt    <= cnt + PRESC_W'(1);
    end
  end

`ifdef LED_PIO_CTRL_PWM_EN
  logic [7:0] duty;
  logic [7:0] pwm_cnt;

  // pwm_cnt is free-running; DUTY writes never disturb it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty    <= 8'hFF;
      pwm_cnt <= 8'h00;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (wr && address == ADDR_DUTY) begin
        duty <= writedata[7:0];
      end
    end
  end

  // 0xFF is special-cased so full duty is truly always on.
  assign pwm_on = (duty == 8'hFF) | (pwm_cnt < duty);
`else
  assign pwm_on = 1'b1;
`endif

  // Blinking bits are forced off during phase 0.
  assign out_next = data_reg & ~(blink_mask & {WIDTH{~phase}}) & {WIDTH{pwm_on}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE;
    end else begin
      out_port <= out_next;
    end
  end

  // Read mux; pure function of address and state, write-only and
  // reserved addresses read as zero.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata = 32'(data_reg);
      ADDR_MASK:   readdata = 32'(blink_mask);
      ADDR_PERIOD: readdata = 32'(period);
      ADDR_STATUS: readdata = {30'd0, (period != '0), phase};
`ifdef LED_PIO_CTRL_PWM_EN
      ADDR_DUTY:   readdata = {24'd0, duty};
`endif
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pio_ctrl.sv
// tb_led_pio_ctrl
//   Scoreboard bench for led_pio_ctrl (WIDTH=8, RESET_VALUE=8'hA5).
//   Stimulus pushes expected out_port/readdata values tagged with the cycle
//   they are due; a monitor on the falling edge pops and compares them.
//   PWM checks are compiled only when LED_PIO_CTRL_PWM_EN is defined.
module tb_led_pio_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int          due;
    bit          is_read;
    logic [31:0] exp;
    string       name;
  } entry_t;

  entry_t sb_q[$];
  entry_t cur;

  led_pio_ctrl #(
    .WIDTH(8),
    .RESET_VALUE(8'hA5),
    .PRESC_W(24)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare every scoreboard entry whose cycle has arrived.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      cur = sb_q.pop_front();
      if (cur.is_read) checkOutput(cur.name, readdata, cur.exp);
      else             checkOutput(cur.name, {24'd0, out_port}, cur.exp);
    end
  end

  task automatic expectOut(input logic [7:0] exp, input int due, input string name);
    entry_t e;
    e.due = due; e.is_read = 1'b0; e.exp = {24'd0, exp}; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic expectRead(input logic [31:0] exp, input int due, input string name);
    entry_t e;
    e.due = due; e.is_read = 1'b1; e.exp = exp; e.name = name;
    sb_q.push_back(e);
  endtask

  // One write cycle; accepted on the second rising edge, returns 1ns after it.
  task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  // Read with chipselect low; readdata is expected not to depend on it.
  task automatic readCheck(input logic [2:0] a, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    address = a;
    expectRead(exp, cyc, name);
    @(negedge clk); #1;
  endtask

  function automatic bit phaseAt(input int c, input int start);
    return (((c - start) / 4) % 2) == 0;
  endfunction

  int p0, e0, q0;

  initial begin
    // Reset state, during and after reset.
    repeat (2) @(posedge clk); #1;
    address = 3'd0;
    expectOut(8'hA5, cyc, "reset out");
    expectRead(32'hA5, cyc, "reset data");
    @(negedge clk); #1;
    reset_n = 1'b1;
    readCheck(3'd3, 32'h1, "reset status");
    @(posedge clk); #1;
    expectOut(8'hA5, cyc, "post-reset out");

    // Set/clear and one-cycle output latency.
    applyStimulus(3'd0, 32'h0F);
    applyStimulus(3'd4, 32'hFFFF_FF30);
    applyStimulus(3'd5, 32'h03);
    expectOut(8'h3F, cyc, "out before clear");
    expectOut(8'h3C, cyc + 1, "out after clear");
    readCheck(3'd0, 32'h3C, "data set/clear");
    readCheck(3'd4, 32'h0, "outset reads 0");
    readCheck(3'd5, 32'h0, "outclear reads 0");
    readCheck(3'd7, 32'h0, "reserved reads 0");

    // Blink: PERIOD=3 gives 4 cycles on, 4 off on bit 0.
    applyStimulus(3'd0, 32'hFF);
    applyStimulus(3'd1, 32'h01);
    applyStimulus(3'd2, 32'h3);
    p0 = cyc;
    address = 3'd3;
    for (int c = p0 + 1; c <= p0 + 16; c++) begin
      expectOut(phaseAt(c - 1, p0) ? 8'hFF : 8'hFE, c, $sformatf("blink out c%0d", c - p0));
      expectRead(phaseAt(c, p0) ? 32'h3 : 32'h2, c, $sformatf("blink status c%0d", c - p0));
    end
    repeat (16) @(posedge clk);
    @(negedge clk); #1;

    // PERIOD=0 written on a terminal-count edge: the write wins.
    while (((cyc + 2 - p0) % 4) != 0) begin
      @(posedge clk); #1;
    end
    applyStimulus(3'd2, 32'h0);
    e0 = cyc;
    address = 3'd3;
    for (int c = e0; c <= e0 + 4; c++) begin
      expectOut(8'hFF, c, $sformatf("stop out c%0d", c - e0));
      expectRead(32'h1, c, $sformatf("stop status c%0d", c - e0));
    end
    repeat (4) @(posedge clk);
    @(negedge clk); #1;

    // Asynchronous reset while phase=0.
    applyStimulus(3'd2, 32'h3);
    q0 = cyc;
    address = 3'd3;
    expectOut(8'hFE, q0 + 5, "pre-reset blink off");
    expectRead(32'h2, q0 + 5, "pre-reset status");
    repeat (6) @(posedge clk); #1;
    reset_n = 1'b0;
    address = 3'd0;
    expectOut(8'hA5, cyc, "async reset out");
    expectRead(32'hA5, cyc, "async reset data");
    @(negedge clk); #1;
    @(posedge clk); @(negedge clk); #1;
    reset_n = 1'b1;
    readCheck(3'd1, 32'h0, "mask after reset");
    readCheck(3'd2, 32'h0, "period after reset");
    readCheck(3'd3, 32'h1, "status after reset");

    // Reserved address: writes ignored.
    applyStimulus(3'd7, 32'h12);
    readCheck(3'd7, 32'h0, "reserved write ignored");
    readCheck(3'd0, 32'hA5, "data unaffected");

`ifdef LED_PIO_CTRL_PWM_EN
    readCheck(3'd6, 32'hFF, "duty reset");
    applyStimulus(3'd0, 32'h01);
    begin
      logic [7:0] duties [3] = '{8'h40, 8'h00, 8'hFF};
      int         highs  [3] = '{64, 0, 256};
      for (int k = 0; k < 3; k++) begin
        int high;
        applyStimulus(3'd6, {24'd0, duties[k]});
        repeat (3) @(posedge clk);
        high = 0;
        for (int i = 0; i < 256; i++) begin
          @(negedge clk);
          if (out_port[0]) high++;
        end
        checkOutput($sformatf("pwm duty 0x%02h high count", duties[k]), 32'(high), 32'(highs[k]));
      end
    end
`else
    applyStimulus(3'd6, 32'hFF);
    readCheck(3'd6, 32'h0, "duty absent reads 0");
`endif

    for (int i = 0; i < 50 && sb_q.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    if (sb_q.size() > 0) begin
      failures += sb_q.size();
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/led_pio_ctrl.md
Name: led_pio_ctrl

Overview:
Parametrised Avalon-MM output PIO for board LEDs and general-purpose outputs, successor to the fixed 8-bit LED port. Adds atomic set/clear writes, a per-bit hardware blink mask driven by a programmable prescaler, and a registered, glitch-free output stage. Sits on the Nios II system interconnect as a zero-wait-state slave.

Parameters:
WIDTH, 8, number of output bits; legal range 1..32.
RESET_VALUE, 0, DATA register value after reset; WIDTH bits.
PRESC_W, 24, width of the PERIOD register and the blink prescaler counter; legal range 1..32.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  3  word address of register
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  read data; combinational, zero wait states
out_port  output  WIDTH  registered LED/GPIO drive

Behaviour:
- Reset: clk and reset_n; reset_n is asynchronous and active-low. In reset: DATA=RESET_VALUE, BLINK_MASK=0, PERIOD=0, cnt=0, phase=1, out_port=RESET_VALUE (DUTY=0xFF when the option is built).
- Write strobe: wr = chipselect & ~write_n. writedata[WIDTH-1:0] is used. Upper bits are ignored.
- Register map (word address, access):
  - 0 DATA, rw: DATA <= wd.
  - 1 BLINK_MASK, rw.
  - 2 PERIOD, rw, PRESC_W bits. A write also clears cnt to 0 and sets phase to 1 on the same edge.
  - 3 STATUS, ro: bit0=phase, bit1=(PERIOD!=0), other bits 0.
  - 4 OUTSET, wo: DATA <= DATA | wd. Reads return 0.
  - 5 OUTCLEAR, wo: DATA <= DATA & ~wd. Reads return 0.
  - 6 DUTY: see Optional Feature.
  - 7: reserved. Reads return 0; writes are ignored.
- Readdata: zero-extended to 32 bits. It is a pure function of address and the register state, independent of chipselect. A read has no side effects.
- Prescaler:
  - PERIOD==0: blink disabled; cnt held 0, phase held 1.
  - PERIOD!=0: each clk, if cnt==PERIOD then cnt<=0 and phase toggles; otherwise cnt<=cnt+1.
  - Phase half-period is therefore PERIOD+1 cycles; full blink period is 2*(PERIOD+1) cycles.
  - If a PERIOD write coincides with the terminal count, the write wins: cnt=0, phase=1.
- Output:
  - out_next = DATA & ~(BLINK_MASK & {WIDTH{~phase}}), ANDed with pwm_on when the option is built.
  - out_port <= out_next every clk.
  - Latency: a write accepted at edge N updates the register at N; out_port reflects it at edge N+1.
  - A blink phase toggle at edge N is visible on out_port at edge N+1.
- A bit with BLINK_MASK=1 and DATA=0 stays off. A blinking bit is on while phase=1.
- Reset asserted mid-blink returns to the reset state immediately, asynchronously; the blink restarts with phase=1 after release.

Optional Feature:
LED_PIO_CTRL_PWM_EN.
- Defined:
  - Address 6 DUTY is rw, 8 bits, reset 0xFF.
  - An 8-bit free-running pwm_cnt increments every clk and wraps 0xFF->0x00.
  - pwm_on = (DUTY==0xFF) | (pwm_cnt < DUTY), so DUTY=0 means always off and DUTY=0xFF means always on.
  - A DUTY write takes effect on the next pwm_cnt comparison without resetting pwm_cnt.
- Undefined: address 6 reads 0, writes are ignored, pwm_on is constant 1, and no pwm_cnt logic is built.

Test Plan:
- Reset value: reset with RESET_VALUE=8'hA5 -> out_port=8'hA5 during and after reset, readdata@0=0x000000A5, readdata@3=0x1.
- Set/clear and latency: write DATA=0x0F, OUTSET=0x30, then OUTCLEAR=0x03 -> DATA reads 0x3C; out_port=0x3C one cycle after the last write; reads of addresses 4 and 5 return 0.
- Blink period: DATA=0xFF, BLINK_MASK=0x01, PERIOD=3 -> out_port[0] alternates 4 cycles on, 4 cycles off; bits 7:1 stay 1; STATUS bit0 tracks phase.
- Boundary: with PERIOD=3 running, write PERIOD=0 on the terminal-count cycle -> phase=1, cnt=0, out_port[0]=1 held; STATUS=0x1.
- Mid-blink reset: assert reset_n=0 asynchronously while phase=0 -> out_port=RESET_VALUE before the next clk edge; after release BLINK_MASK=0 and PERIOD=0.
- PWM (LED_PIO_CTRL_PWM_EN): DATA=0x01, DUTY=0x40 -> out_port[0] high for exactly 64 of every 256 cycles; DUTY=0x00 -> always low; DUTY=0xFF -> always high.
